// File: rtl/vram_arbiter.sv
// Single-port VRAM access arbiter: video scanout has default priority, the CPU
// bridge gets a one-entry request buffer and a bounded-wait starvation guard.
module vram_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic        vid_grant,
  output logic        vid_valid,
  output logic [7:0]  vid_rdata,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

  // Legal MAX_WAIT range is 0..15, which fits the 4-bit counter exactly.
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic        pending_q,    pending_d;
  logic        buf_we_q,     buf_we_d;
  logic [14:0] buf_addr_q,   buf_addr_d;
  logic [7:0]  buf_wdata_q,  buf_wdata_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  rdata_hold_q, rdata_hold_d;
  owner_e      owner_q,      owner_d;

  logic starve_sat;
  logic cpu_grant;
  logic vid_grant_w;
  logic busy_w;
  logic cpu_rd_done;

  // Once the guard saturates, a pending CPU access beats video for one cycle.
  assign starve_sat  = (starve_cnt_q >= MAX_WAIT_C);
  assign cpu_grant   = pending_q && (!vid_req || starve_sat);
  assign vid_grant_w = vid_req && !cpu_grant;
  assign busy_w      = pending_q || (owner_q == OWN_CPU);
  assign cpu_rd_done = (owner_q == OWN_CPU) && !buf_we_q;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      starve_cnt_q <= '0;
      rdata_hold_q <= 8'h00;
      owner_q      <= OWN_NONE;
    end else begin
      pending_q    <= pending_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      starve_cnt_q <= starve_cnt_d;
      rdata_hold_q <= rdata_hold_d;
      owner_q      <= owner_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    pending_d    = pending_q;
    buf_we_d     = buf_we_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    starve_cnt_d = starve_cnt_q;
    rdata_hold_d = rdata_hold_q;
    owner_d      = OWN_NONE;

    // Grant needs pending=1 and acceptance needs busy=0, so the two never overlap.
    if (cpu_grant) begin
      pending_d = 1'b0;
    end else if (!busy_w && cpu_req) begin
      pending_d   = 1'b1;
      buf_we_d    = cpu_we;
      buf_addr_d  = cpu_addr;
      buf_wdata_d = cpu_wdata;
    end

    if (cpu_grant) begin
      starve_cnt_d = '0;
    end else if (pending_q && !starve_sat) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (cpu_grant) begin
      owner_d = OWN_CPU;
    end else if (vid_grant_w) begin
      owner_d = OWN_VID;
    end

    // The buffer cannot be reloaded during the done cycle, so buf_we_q still
    // describes the access that is completing.
    if (cpu_rd_done) begin
      rdata_hold_d = ram_dout;
    end
  end

  always_comb begin
    cpu_busy  = busy_w;
    cpu_done  = (owner_q == OWN_CPU);
    cpu_rdata = cpu_rd_done ? ram_dout : rdata_hold_q;
    vid_grant = vid_grant_w;
    vid_valid = (owner_q == OWN_VID);
    vid_rdata = ram_dout;
    ram_addr  = cpu_grant ? buf_addr_q : vid_addr;
    ram_we    = cpu_grant && buf_we_q;
    ram_din   = buf_wdata_q;
  end

  a_one_owner : assert property (@(posedge clk) disable iff (!reset_n)
    !(cpu_grant && vid_grant_w));
  a_we_cpu_only : assert property (@(posedge clk) disable iff (!reset_n)
    ram_we |-> cpu_grant);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: two instances (MAX_WAIT=4 and 0), each
// with a byte-wide registered-read VRAM model preloaded with data=addr.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_busy, cpu_done;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        vid_req, vid_grant, vid_valid;
  logic [14:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din, ram_dout;

  logic        z_cpu_req, z_cpu_we, z_cpu_busy, z_cpu_done;
  logic [14:0] z_cpu_addr;
  logic [7:0]  z_cpu_wdata, z_cpu_rdata;
  logic        z_vid_req, z_vid_grant, z_vid_valid;
  logic [14:0] z_vid_addr;
  logic [7:0]  z_vid_rdata;
  logic [14:0] z_ram_addr;
  logic        z_ram_we;
  logic [7:0]  z_ram_din, z_ram_dout;

  vram_arbiter #(.MAX_WAIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  vram_arbiter #(.MAX_WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_busy(z_cpu_busy), .cpu_done(z_cpu_done), .cpu_rdata(z_cpu_rdata),
    .vid_req(z_vid_req), .vid_addr(z_vid_addr), .vid_grant(z_vid_grant),
    .vid_valid(z_vid_valid), .vid_rdata(z_vid_rdata),
    .ram_addr(z_ram_addr), .ram_we(z_ram_we), .ram_din(z_ram_din), .ram_dout(z_ram_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem   [0:32767];
  logic [7:0] z_mem [0:32767];
  logic       preloaded = 1'b0;

  // VRAM models; the first edge preloads data=addr (reset is held then).
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 32768; i++) begin
        mem[i]   <= 8'(i);
        z_mem[i] <= 8'(i);
      end
      preloaded <= 1'b1;
    end else begin
      if (ram_we)   mem[ram_addr]     <= ram_din;
      if (z_ram_we) z_mem[z_ram_addr] <= z_ram_din;
    end
    ram_dout   <= mem[ram_addr];
    z_ram_dout <= z_mem[z_ram_addr];
  end

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
  } cpu_exp_t;

  cpu_exp_t   cpu_q[$];
  logic [7:0] vid_q[$];
  logic [7:0] ref_wr [int];
  logic [7:0] last_rd = 8'h00;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] ref_val(input logic [14:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return a[7:0];
  endfunction

  // Scoreboard update, run once per sampled cycle before the scenario checks.
  task automatic score();
    cpu_exp_t   e;
    logic [7:0] v;
    if (!reset_n) begin
      cpu_q.delete();
      vid_q.delete();
      last_rd = 8'h00;
    end else begin
      if (cpu_done) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("FAIL cpu_done_spurious: cpu_done=1 got, no access outstanding required");
        end else begin
          e = cpu_q.pop_front();
          if (e.we) ref_wr[int'(e.addr)] = e.data;
          else      last_rd = e.data;
          checks++;
          if (cpu_rdata !== last_rd) begin
            errors++;
            $display("FAIL cpu_rdata_sb: got %h required %h", cpu_rdata, last_rd);
          end
        end
      end
      if (vid_valid) begin
        checks++;
        if (vid_q.size() == 0) begin
          errors++;
          $display("FAIL vid_valid_spurious: vid_valid=1 got, no grant outstanding required");
        end else begin
          v = vid_q.pop_front();
          if (vid_rdata !== v) begin
            errors++;
            $display("FAIL vid_rdata_sb: got %h required %h", vid_rdata, v);
          end
        end
      end
      if (vid_grant) vid_q.push_back(ref_val(vid_addr));
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_sample();
    @(negedge clk);
    score();
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0001; cpu_wdata = 8'hEE;
    z_cpu_req = 1'b1; z_cpu_we = 1'b1; z_cpu_addr = 15'h0001; z_cpu_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      cycle_sample();
      checks++;
      if ({ram_we, z_ram_we, cpu_busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset_no_write: {ram_we,z_ram_we,busy} got %b required 000", {ram_we, z_ram_we, cpu_busy});
      end
    end
    cpu_req = 1'b0;
    z_cpu_req = 1'b0;
    reset_n = 1'b1;
    cycle_begin();
    cycle_sample();
    checks++;
    if ({cpu_busy, cpu_done, vid_valid, vid_grant, ram_we, cpu_rdata} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {cpu_busy, cpu_done, vid_valid, vid_grant, ram_we, cpu_rdata});
    end
    checks++;
    if (mem[1] !== 8'h01) begin
      errors++;
      $display("FAIL reset_mem_intact: got %h required 01", mem[1]);
    end
  endtask

  task automatic test_cpu_write_read();
    cycle_begin();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'h5A;
    cpu_q.push_back('{we: 1'b1, addr: 15'h1234, data: 8'h5A});
    cycle_sample();
    checks++;
    if (cpu_busy !== 1'b0) begin
      errors++; $display("FAIL wr_accept_busy: got %b required 0", cpu_busy);
    end
    cycle_begin();
    cpu_req = 1'b0;
    cycle_sample();
    checks++;
    if ({ram_we, ram_addr, ram_din, vid_grant, cpu_done, cpu_busy} !== {1'b1, 15'h1234, 8'h5A, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wr_grant: {we,addr,din,vg,done,busy} got %b %h %h %b %b %b required 1 1234 5a 0 0 1",
               ram_we, ram_addr, ram_din, vid_grant, cpu_done, cpu_busy);
    end
    cycle_begin();
    cycle_sample();
    checks++;
    if ({cpu_done, ram_we, cpu_busy} !== 3'b101) begin
      errors++; $display("FAIL wr_done: {done,we,busy} got %b required 101", {cpu_done, ram_we, cpu_busy});
    end
    cycle_begin();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234; cpu_wdata = 8'h00;
    cpu_q.push_back('{we: 1'b0, addr: 15'h1234, data: ref_val(15'h1234)});
    cycle_sample();
    checks++;
    if ({cpu_busy, cpu_done} !== 2'b00 || mem[16'h1234] !== 8'h5A) begin
      errors++; $display("FAIL wr_complete: {busy,done} %b mem %h required 00 5a", {cpu_busy, cpu_done}, mem[16'h1234]);
    end
    cycle_begin();
    cpu_req = 1'b0;
    cycle_sample();
    checks++;
    if ({ram_addr, ram_we, cpu_busy} !== {15'h1234, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rd_grant: {addr,we,busy} got %h %b %b required 1234 0 1", ram_addr, ram_we, cpu_busy);
    end
    cycle_begin();
    cycle_sample();
    checks++;
    if ({cpu_done, cpu_rdata} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rd_done: {done,rdata} got %b %h required 1 5a", cpu_done, cpu_rdata);
    end
    // Video traffic changes ram_dout while the CPU read data must hold.
    for (int c = 6; c < 10; c++) begin
      cycle_begin();
      vid_req = (c < 8);
      vid_addr = 15'h0003;
      cycle_sample();
      checks++;
      if ({cpu_done, cpu_rdata} !== {1'b0, 8'h5A}) begin
        errors++; $display("FAIL rd_hold_c%0d: {done,rdata} got %b %h required 0 5a", c, cpu_done, cpu_rdata);
      end
    end
  endtask

  task automatic test_video_stream();
    for (int i = 0; i < 16; i++) begin
      cycle_begin();
      vid_req = 1'b1;
      vid_addr = 15'(i);
      cycle_sample();
      checks++;
      if ({vid_grant, vid_valid, ram_addr, ram_we} !== {1'b1, (i != 0), 15'(i), 1'b0}) begin
        errors++;
        $display("FAIL stream_%0d: {vg,vv,addr,we} got %b %b %h %b required 1 %b %h 0",
                 i, vid_grant, vid_valid, ram_addr, ram_we, (i != 0), 15'(i));
      end
    end
    cycle_begin();
    vid_req = 1'b0;
    cycle_sample();
    checks++;
    if ({vid_grant, vid_valid} !== 2'b01) begin
      errors++; $display("FAIL stream_tail: {vg,vv} got %b required 01", {vid_grant, vid_valid});
    end
    cycle_begin();
    cycle_sample();
    checks++;
    if (vid_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: vid_valid got %b required 0", vid_valid);
    end
  endtask

  task automatic test_starvation();
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wd;
    logic        exp_vv;
    for (int r = 0; r < 2; r++) begin
      we   = (r == 1);
      addr = (r == 0) ? 15'h7FFF : 15'h7FFE;
      wd   = (r == 0) ? 8'h77 : 8'hC3;
      for (int c = 0; c < 7; c++) begin
        cycle_begin();
        vid_req  = 1'b1;
        vid_addr = 15'h0100 + 15'(c) + 15'(8 * r);
        cpu_req  = (c == 0);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (c == 0) cpu_q.push_back('{we: we, addr: addr, data: we ? wd : ref_val(addr)});
        cycle_sample();
        exp_vv = (c == 0) ? (r == 1) : (c != 6);
        checks++;
        if ({vid_grant, vid_valid, cpu_busy, cpu_done} !== {(c != 5), exp_vv, (c >= 1), (c == 6)}) begin
          errors++;
          $display("FAIL starve_r%0d_c%0d: {vg,vv,busy,done} got %b required %b", r, c,
                   {vid_grant, vid_valid, cpu_busy, cpu_done}, {(c != 5), exp_vv, (c >= 1), (c == 6)});
        end
        if (c == 5) begin
          checks++;
          if ({ram_addr, ram_we, ram_din} !== {addr, we, wd}) begin
            errors++; $display("FAIL starve_r%0d_drive: {addr,we,din} got %h %b %h required %h %b %h",
                               r, ram_addr, ram_we, ram_din, addr, we, wd);
          end
        end
        if (c == 6) begin
          checks++;
          if (cpu_rdata !== 8'hFF) begin
            errors++; $display("FAIL starve_r%0d_rdata: got %h required ff", r, cpu_rdata);
          end
        end
      end
    end
    cycle_begin();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    cycle_sample();
    cycle_begin();
    cycle_sample();
    checks++;
    if ({mem[16'h7FFE], mem[16'h7FFF]} !== 16'hC3FF) begin
      errors++; $display("FAIL starve_mem: got %h required c3ff", {mem[16'h7FFE], mem[16'h7FFF]});
    end
  endtask

  task automatic test_max_wait_zero();
    cycle_begin();
    z_vid_req = 1'b1; z_vid_addr = 15'h0040;
    z_cpu_req = 1'b1; z_cpu_we = 1'b1; z_cpu_addr = 15'h0ABC; z_cpu_wdata = 8'h3C;
    cycle_sample();
    checks++;
    if ({z_vid_grant, z_cpu_busy} !== 2'b10) begin
      errors++; $display("FAIL mw0_accept: {vg,busy} got %b required 10", {z_vid_grant, z_cpu_busy});
    end
    cycle_begin();
    z_cpu_req = 1'b0; z_vid_addr = 15'h0041;
    cycle_sample();
    checks++;
    if ({z_vid_grant, z_ram_we, z_ram_addr} !== {1'b0, 1'b1, 15'h0ABC}) begin
      errors++; $display("FAIL mw0_grant: {vg,we,addr} got %b %b %h required 0 1 0abc", z_vid_grant, z_ram_we, z_ram_addr);
    end
    cycle_begin();
    z_vid_addr = 15'h0042;
    cycle_sample();
    checks++;
    if ({z_cpu_done, z_vid_grant, z_vid_valid} !== 3'b110) begin
      errors++; $display("FAIL mw0_done: {done,vg,vv} got %b required 110", {z_cpu_done, z_vid_grant, z_vid_valid});
    end
    cycle_begin();
    z_vid_req = 1'b0;
    cycle_sample();
    checks++;
    if ({z_vid_valid, z_cpu_busy, z_mem[16'h0ABC]} !== {1'b1, 1'b0, 8'h3C}) begin
      errors++; $display("FAIL mw0_after: {vv,busy,mem} got %b %b %h required 1 0 3c", z_vid_valid, z_cpu_busy, z_mem[16'h0ABC]);
    end
  endtask

  task automatic test_reset_mid();
    cycle_begin();
    vid_req = 1'b1; vid_addr = 15'h0200;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h2222; cpu_wdata = 8'h99;
    cpu_q.push_back('{we: 1'b1, addr: 15'h2222, data: 8'h99});
    cycle_sample();
    checks++;
    if (cpu_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_accept: busy got %b required 0", cpu_busy);
    end
    cycle_begin();
    cpu_req = 1'b0;
    reset_n = 1'b0;
    cycle_sample();
    checks++;
    if ({ram_we, cpu_busy, cpu_done, vid_valid} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_in_reset: {we,busy,done,vv} got %b required 0000", {ram_we, cpu_busy, cpu_done, vid_valid});
    end
    cycle_begin();
    vid_req = 1'b0;
    cycle_sample();
    reset_n = 1'b1;
    for (int c = 3; c < 9; c++) begin
      cycle_begin();
      cycle_sample();
      checks++;
      if ({ram_we, cpu_busy, cpu_done, cpu_rdata} !== 11'h0) begin
        errors++; $display("FAIL rstmid_after_c%0d: {we,busy,done,rdata} got %b %b %b %h required 0 0 0 00",
                           c, ram_we, cpu_busy, cpu_done, cpu_rdata);
      end
    end
    checks++;
    if (mem[16'h2222] !== 8'h22) begin
      errors++; $display("FAIL rstmid_mem: got %h required 22", mem[16'h2222]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_addr = '0; z_cpu_wdata = '0;
    z_vid_req = 1'b0; z_vid_addr = '0;

    test_reset();
    test_cpu_write_read();
    test_video_stream();
    test_starvation();
    test_max_wait_zero();
    test_reset_mid();

    checks++;
    if (cpu_q.size() != 0 || vid_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: cpu_q %0d vid_q %0d outstanding, required 0 0", cpu_q.size(), vid_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port access controller directly upstream of the 32 KB synchronous VRAM (byte-wide, 15-bit address, one-cycle registered read latency).
- Multiplexes two requesters onto the RAM port:
  - the video scanout fetcher, which is latency-critical and has default priority;
  - the CPU bus bridge, which uses a one-entry request buffer plus a starvation guard.
- Drives the RAM address, write-enable and data lines combinationally from the current grant.
- Returns read data to whichever requester owned the previous cycle.

Parameters:
- MAX_WAIT, default 4: cycles a pending CPU request may be refused in favour of video before it is forced through. 0 gives the CPU absolute priority. Legal range 0..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, sampled only when cpu_busy=0
- cpu_we  input  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  input  15  CPU byte address; sampled with cpu_req
- cpu_wdata  input  8  CPU write data; sampled with cpu_req
- cpu_busy  output  1  request buffered or in flight; new requests ignored while high
- cpu_done  output  1  one-cycle pulse, access completed
- cpu_rdata  output  8  read data; valid in the cpu_done cycle, held stable until the next CPU read completes
- vid_req  input  1  video fetch request this cycle
- vid_addr  input  15  video fetch address
- vid_grant  output  1  combinational; vid_addr accepted this cycle
- vid_valid  output  1  registered; vid_rdata valid, i.e. grant was given in the previous cycle
- vid_rdata  output  8  video read data, combinational pass-through of ram_dout
- ram_addr  output  15  to VRAM address
- ram_we  output  1  to VRAM write enable
- ram_din  output  8  to VRAM write data
- ram_dout  input  8  from VRAM; data for the address presented in the previous cycle

Behaviour:
- Reset (async assert, sync release). State cleared:
  - pending=0, starve_cnt=0, last_owner=NONE, rdata_hold=8'h00.
  - Outputs: cpu_busy=0, cpu_done=0, vid_valid=0, cpu_rdata=8'h00, ram_we=0.
- Reset mid-operation:
  - The pending or in-flight CPU access is dropped; no cpu_done follows.
  - No RAM write may occur while reset_n=0.
- CPU acceptance:
  - On the rising edge with cpu_busy=0 and cpu_req=1, latch we/addr/wdata into the buffer and set pending=1.
  - A request is never granted in its acceptance cycle.
- Arbitration (combinational, every cycle):
  - CPU grant if pending=1 and (vid_req=0 or starve_cnt>=MAX_WAIT).
  - Else video grant if vid_req=1.
  - Else idle.
- RAM drive:
  - CPU grant: ram_addr=buffered addr, ram_we=buffered we, ram_din=buffered wdata.
  - Video grant: ram_addr=vid_addr, ram_we=0.
  - Idle: ram_addr=vid_addr, ram_we=0.
  - ram_din equals the buffered wdata at all times.
  - vid_grant=1 only on a video grant.
- Starvation counter:
  - Increments each cycle pending=1 and the CPU is not granted; saturates at MAX_WAIT.
  - Cleared on CPU grant.
  - While starve_cnt>=MAX_WAIT and pending=1, vid_grant=0 even if vid_req=1.
- Edge following a CPU grant: pending=0, last_owner=CPU.
- Cycle after a CPU grant:
  - cpu_done=1.
  - For a read, cpu_rdata=ram_dout combinationally and rdata_hold captures ram_dout. Otherwise cpu_rdata=rdata_hold.
  - Writes do not alter rdata_hold.
- Cycle after a video grant: vid_valid=1; the video requester must consume vid_rdata in that cycle.
- cpu_busy = pending | (last_owner==CPU).
  - Busy is low in the cycle after cpu_done.
  - Minimum CPU latency: accept edge E0, grant in cycle 1, cpu_done in cycle 2, new request accepted at the end of cycle 3.
- Back-to-back video grants are allowed every cycle; vid_valid may stay high continuously.
- Simultaneous vid_req and a starved CPU: the CPU wins for exactly one cycle, then video resumes.
- Address wrap: none. 15-bit addresses map 1:1; 0x7FFF is legal.

Test Plan:
- Reset with vid_req=0 and cpu_req=0 -> all outputs zero; ram_we=0 throughout reset, including a cpu_req=1 asserted during reset.
- CPU write 0x5A to 0x1234 with video idle -> ram_we=1 with ram_addr=0x1234 in cycle 1; cpu_done in cycle 2. A subsequent CPU read of 0x1234 -> cpu_rdata=0x5A at done and held afterwards.
- Video streaming addresses 0x0000..0x000F continuously, RAM preloaded with data=addr -> vid_grant=1 every cycle; vid_valid from cycle 1; vid_rdata=0x00..0x0F in order.
- MAX_WAIT=4, continuous vid_req plus a CPU read of 0x7FFF -> video granted 4 cycles, then exactly one cycle vid_grant=0 with CPU grant; cpu_done next cycle; video resumes.
- MAX_WAIT=0 with continuous vid_req -> CPU granted the first cycle after acceptance.
- reset_n pulsed low the cycle after a CPU write is accepted (pending, not yet granted) -> no ram_we, no cpu_done; cpu_busy=0 after release; target location unchanged.
